// File: rtl/lsq_if.sv
// -----------------------------------------------------------------------------
// lsq_if -- data-port bundle between the load/store queue and the data memory.
//
// Request channel (master -> slave, valid/ready):
//   dreqvalid, dreqhpl, dreqaddr, dreqwr, dreqbe, dreqwdata / dreqready
// Response channel (slave -> master, valid/ready, in request order):
//   drspvalid, drsprerr, drspwerr, drspdata / drspready
//
// Modports: master (the LSQ), slave (the memory or bus bridge).
// -----------------------------------------------------------------------------
interface lsq_if #(
    parameter int XLEN = 32
);
    logic            dreqvalid;
    logic            dreqready;
    logic [1:0]      dreqhpl;
    logic [XLEN-1:0] dreqaddr;
    logic            dreqwr;
    logic [3:0]      dreqbe;
    logic [XLEN-1:0] dreqwdata;

    logic            drspvalid;
    logic            drspready;
    logic            drsprerr;
    logic            drspwerr;
    logic [XLEN-1:0] drspdata;

    modport master (
        output dreqvalid, dreqhpl, dreqaddr, dreqwr, dreqbe, dreqwdata, drspready,
        input  dreqready, drspvalid, drsprerr, drspwerr, drspdata
    );

    modport slave (
        input  dreqvalid, dreqhpl, dreqaddr, dreqwr, dreqbe, dreqwdata, drspready,
        output dreqready, drspvalid, drsprerr, drspwerr, drspdata
    );
endinterface

// File: rtl/lsq.sv
// -----------------------------------------------------------------------------
// lsq -- load/store queue of the merlin32i core.
//
// Accepts loads/stores from ex_stage, issues them in program order on the data
// port, writes load results back to the id_stage register file and reports
// data-bus faults to hvec.
//
// Ports:
//   clk_i, resetb_i (async, active low), clk_en_i (all state holds when low)
//   exs_*           enqueue side from ex_stage, exs_full_o back-pressure
//   dbus            data request/response port (lsq_if.master)
//   ids_reg_*       register write-back to id_stage
//   hvec_*          load/store access-fault pulses and faulting byte address
//
// Build option:
//   MERLIN_LSQ_WB_REG_EN  register the write-back and fault outputs (one cycle
//                         after the response handshake). Undefined: those
//                         outputs are combinational from the handshake.
// -----------------------------------------------------------------------------
module lsq #(
    parameter int C_XLEN    = 32,
    parameter int C_DEPTH_X = 2
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,

    input  logic [1:0]        exs_hpl_i,
    output logic              exs_full_o,
    input  logic              exs_lq_wr_i,
    input  logic              exs_sq_wr_i,
    input  logic [2:0]        exs_funct3_i,
    input  logic [4:0]        exs_regd_addr_i,
    input  logic [C_XLEN-1:0] exs_regs2_data_i,
    input  logic [C_XLEN-1:0] exs_addr_i,

    lsq_if.master             dbus,

    output logic              ids_reg_wr_o,
    output logic [4:0]        ids_reg_addr_o,
    output logic [C_XLEN-1:0] ids_reg_data_o,

    output logic              hvec_lerr_o,
    output logic              hvec_serr_o,
    output logic [C_XLEN-1:0] hvec_err_addr_o
);
    localparam int DEPTH = 1 << C_DEPTH_X;
    localparam int PTR_W = C_DEPTH_X + 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [PTR_W-1:0] ptr_t;

    // Entry storage, one array per field.
    logic              st_q   [DEPTH];
    logic [2:0]        f3_q   [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [1:0]        hpl_q  [DEPTH];
    logic [C_XLEN-1:0] addr_q [DEPTH];
    logic [C_XLEN-1:0] data_q [DEPTH];

    // Pointers carry one wrap bit so full (wr - ret == DEPTH) and empty differ.
    ptr_t wr_q, iss_q, ret_q;
    ptr_t wr_d, iss_d, ret_d;

    logic [C_DEPTH_X-1:0] wr_idx, iss_idx, ret_idx;
    logic                 enq, req_valid, req_fire, rsp_fire;

    assign wr_idx  = wr_q[C_DEPTH_X-1:0];
    assign iss_idx = iss_q[C_DEPTH_X-1:0];
    assign ret_idx = ret_q[C_DEPTH_X-1:0];

    assign exs_full_o = (ptr_t'(wr_q - ret_q) == ptr_t'(DEPTH));
    assign enq        = clk_en_i & (exs_lq_wr_i | exs_sq_wr_i) & ~exs_full_o;

    assign req_valid      = (iss_q != wr_q);
    assign dbus.dreqvalid = req_valid;
    assign req_fire       = req_valid & dbus.dreqready & clk_en_i;

    assign dbus.drspready = (ret_q != iss_q);
    assign rsp_fire       = dbus.drspvalid & dbus.drspready & clk_en_i;

    assign wr_d  = wr_q  + ptr_t'(enq);
    assign iss_d = iss_q + ptr_t'(req_fire);
    assign ret_d = ret_q + ptr_t'(rsp_fire);

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_q  <= '0;
            iss_q <= '0;
            ret_q <= '0;
        end else begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            wr_q  <= wr_d;
            iss_q <= iss_d;
            ret_q <= ret_d;
        end
    end

    // NOTE: entry storage has no reset; every read of it is qualified by a
    // pointer comparison, so stale contents never reach an output.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            st_q[wr_idx]   <= ~exs_lq_wr_i;   // load wins when both strobes are high
            f3_q[wr_idx]   <= exs_funct3_i;
            rd_q[wr_idx]   <= exs_regd_addr_i;
            hpl_q[wr_idx]  <= exs_hpl_i;
            addr_q[wr_idx] <= exs_addr_i;
            data_q[wr_idx] <= exs_regs2_data_i;
        end
    end

    // Request fields come straight from the entry at iss, forced to 0 when idle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        dbus.dreqhpl   = '0;
        dbus.dreqaddr  = '0;
        dbus.dreqwr    = 1'b0;
        dbus.dreqbe    = '0;
        dbus.dreqwdata = '0;
        if (req_valid) begin
            dbus.dreqhpl   = hpl_q[iss_idx];
            dbus.dreqaddr  = {addr_q[iss_idx][C_XLEN-1:2], 2'b00};
            dbus.dreqwr    = st_q[iss_idx];
            dbus.dreqbe    = 4'b1111;
            dbus.dreqwdata = data_q[iss_idx];
            if (st_q[iss_idx]) begin
                case (f3_q[iss_idx])
                    F3_B: begin
                        dbus.dreqbe    = 4'b0001 << addr_q[iss_idx][1:0];
                        dbus.dreqwdata = {4{data_q[iss_idx][7:0]}};
                    end
                    F3_H: begin
                        dbus.dreqbe    = 4'b0011 << {addr_q[iss_idx][1], 1'b0};
                        dbus.dreqwdata = {2{data_q[iss_idx][15:0]}};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Load extraction from the response word, selected by the retiring entry.
    logic [C_XLEN-1:0] ret_addr;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [C_XLEN-1:0] ld_data;

    assign ret_addr = addr_q[ret_idx];
    assign ld_byte  = 8'(dbus.drspdata >> {ret_addr[1:0], 3'b000});
    assign ld_half  = 16'(dbus.drspdata >> {ret_addr[1], 4'b0000});

    always_comb begin
        case (f3_q[ret_idx])
            F3_B:    ld_data = {{(C_XLEN-8){ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{(C_XLEN-16){ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {{(C_XLEN-8){1'b0}}, ld_byte};
            F3_HU:   ld_data = {{(C_XLEN-16){1'b0}}, ld_half};
            default: ld_data = dbus.drspdata;   // LW and the unused encodings
        endcase
    end

    logic wb_wr_d, lerr_d, serr_d;

    assign wb_wr_d = rsp_fire & ~st_q[ret_idx] & ~dbus.drsprerr & (rd_q[ret_idx] != 5'd0);
    assign lerr_d  = rsp_fire & ~st_q[ret_idx] & dbus.drsprerr;
    assign serr_d  = rsp_fire &  st_q[ret_idx] & dbus.drspwerr;

`ifdef MERLIN_LSQ_WB_REG_EN
    logic              wb_wr_q, lerr_q, serr_q;
    logic [4:0]        wb_addr_q;
    logic [C_XLEN-1:0] wb_data_q, err_addr_q;

    // Data and address hold their last value between events.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wb_wr_q    <= 1'b0;
            lerr_q     <= 1'b0;
            serr_q     <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            err_addr_q <= '0;
        end else if (clk_en_i) begin
            wb_wr_q <= wb_wr_d;
            lerr_q  <= lerr_d;
            serr_q  <= serr_d;
            if (wb_wr_d) begin
                wb_addr_q <= rd_q[ret_idx];
                wb_data_q <= ld_data;
            end
            if (lerr_d | serr_d) begin
                err_addr_q <= ret_addr;
            end
        end
    end

    assign ids_reg_wr_o    = wb_wr_q;
    assign ids_reg_addr_o  = wb_addr_q;
    assign ids_reg_data_o  = wb_data_q;
    assign hvec_lerr_o     = lerr_q;
    assign hvec_serr_o     = serr_q;
    assign hvec_err_addr_o = err_addr_q;
`else
    assign ids_reg_wr_o    = wb_wr_d;
    assign ids_reg_addr_o  = wb_wr_d ? rd_q[ret_idx] : 5'd0;
    assign ids_reg_data_o  = wb_wr_d ? ld_data : '0;
    assign hvec_lerr_o     = lerr_d;
    assign hvec_serr_o     = serr_d;
    assign hvec_err_addr_o = (lerr_d | serr_d) ? ret_addr : '0;
`endif

endmodule
